dbg_cmd_arbiter: RTL and testbench

Shares the single debug command bus of the core debug module between N_REQ debug requesters (e.g. UART bridge, JTAG bridge). It grants one requester at a time round-robin and drives cmd/addr/data to the core debug module until dut_done. It then returns the read data to the winner and forces a no-command (0x00) gap so a command never executes twice. It also applies a timeout so unsupported commands cannot hang the bus, and tracks the core halted state.

---
 rtl/dbg_cmd_arbiter_if.sv | 36 +++
 rtl/dbg_cmd_arbiter.sv | 147 ++++++++++++++
 tb/tb_dbg_cmd_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_cmd_arbiter_if.sv
// Requester-side command/response bundle of the debug command arbiter.
// Slices i of cmd/addr/data belong to requester i.
interface dbg_cmd_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid_i;
  logic [8*N_REQ-1:0]  req_cmd_i;
  logic [32*N_REQ-1:0] req_addr_i;
  logic [32*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ-1:0]    rsp_valid_o;
  logic [31:0]         rsp_data_o;
  logic                rsp_err_o;

  modport slave (
    input  req_valid_i,
    input  req_cmd_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_data_o,
    output rsp_err_o
  );

  modport master (
    output req_valid_i,
    output req_cmd_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_data_o,
    input  rsp_err_o
  );
endinterface

// File: rtl/dbg_cmd_arbiter.sv
// Round-robin arbiter sharing the core debug command bus between
// requesters, with timeout abort and a one-cycle no-command gap.
module dbg_cmd_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn_i,
  dbg_cmd_arbiter_if.slave req,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_done_i,
  output logic        core_halted_o,
  output logic        busy_o
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_HALT   = 8'h01;
  localparam logic [7:0] CMD_RESUME = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COOLDOWN
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     rr_q;
  logic [IW-1:0]     id_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        cmd_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              halted_q;

  logic              found;
  logic [IW-1:0]     win;
  logic [7:0]        win_cmd;
  logic [31:0]       win_addr;
  logic [31:0]       win_data;
  logic              accept;
  logic              tmo;

  // First valid requester above the last winner, wrapping around.
  always_comb begin : p_search
    int k;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && req.req_valid_i[IW'(k)]) begin
        found = 1'b1;
        win   = IW'(k);
      end
    end
  end

  assign win_cmd  = req.req_cmd_i[int'(win)*8 +: 8];
  assign win_addr = req.req_addr_i[int'(win)*32 +: 32];
  assign win_data = req.req_data_i[int'(win)*32 +: 32];

  assign accept = (state_q == IDLE) && found;
  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

  assign req.req_ready_o = (accept && rstn_i)
                         ? (N_REQ'(1) << win)
                         : '0;
  assign req.rsp_valid_o = rsp_valid_q;
  assign req.rsp_data_o  = rsp_data_q;
  assign req.rsp_err_o   = rsp_err_q;

  assign dbg_cmd_o     = cmd_q;
  assign dbg_addr_o    = addr_q;
  assign dbg_data_o    = data_q;
  assign core_halted_o = halted_q;
  assign busy_o        = (state_q != IDLE);

  // cmd/addr/data registers double as the bus drivers: they are
  // only non-zero while in ISSUE.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rr_q        <= IW'(N_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            rr_q  <= win;
            id_q  <= win;
            cnt_q <= '0;
            if (win_cmd == CMD_NOP) begin
              rsp_valid_q <= N_REQ'(1) << win;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
            end else begin
              cmd_q   <= win_cmd;
              addr_q  <= win_addr;
              data_q  <= win_data;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (dbg_done_i || tmo) begin
            rsp_valid_q <= N_REQ'(1) << id_q;
            rsp_data_q  <= dbg_done_i ? dbg_data_i : '0;
            rsp_err_q   <= !dbg_done_i;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            state_q     <= COOLDOWN;
            if (dbg_done_i && cmd_q == CMD_HALT)
              halted_q <= 1'b1;
            if (dbg_done_i && cmd_q == CMD_RESUME)
              halted_q <= 1'b0;
          end
        end
        COOLDOWN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_cmd_arbiter.sv
// Directed bench for dbg_cmd_arbiter with a scoreboard of
// expected responses and a registered model core debug module.
module tb_dbg_cmd_arbiter;
  localparam int N  = 2;
  localparam int TO = 12;
  localparam logic [31:0] PC = 32'h8000_0010;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  dbg_cmd;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_done;
  logic        halted;
  logic        busy;

  int   errs = 0;
  int   checks = 0;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  dbg_cmd_arbiter_if #(.N_REQ(N)) rq ();

  dbg_cmd_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rstn_i        (rstn),
    .req           (rq),
    .dbg_cmd_o     (dbg_cmd),
    .dbg_addr_o    (dbg_addr),
    .dbg_data_o    (dbg_wdata),
    .dbg_data_i    (dbg_rdata),
    .dbg_done_i    (dbg_done),
    .core_halted_o (halted),
    .busy_o        (busy)
  );

  // Model core: done one cycle after a supported command appears;
  // 0x07 is never acknowledged.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_done  <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_done  <= (dbg_cmd != 8'h00) && (dbg_cmd != 8'h07);
      dbg_rdata <= (dbg_cmd == 8'h05) ? PC : dbg_addr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] d,
                      input logic e);
    exp_t x;
    x.id = id;
    x.data = d;
    x.err = e;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rq.rsp_valid_o != '0) begin
      if (sbq.size() == 0) begin
        chk("unexp_rsp", 32'(rq.rsp_valid_o), 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rq.rsp_valid_o), 32'(1 << mon_e.id));
        chk("rsp_data", rq.rsp_data_o, mon_e.data);
        chk("rsp_err", 32'(rq.rsp_err_o), 32'(mon_e.err));
      end
    end
  end

  task automatic set_req(input int id, input logic [7:0] c,
                         input logic [31:0] a,
                         input logic [31:0] d);
    rq.req_cmd_i[id*8 +: 8]   = c;
    rq.req_addr_i[id*32 +: 32] = a;
    rq.req_data_i[id*32 +: 32] = d;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  task automatic do_req(input string tag, input int id,
                        input logic [7:0] c, input logic [31:0] a,
                        input logic [31:0] expd);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(id, c, a, 32'h0);
    rq.req_valid_i[id] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rq.req_ready_o[id]) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'h1);
    if (got) push(id, expd, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i[id] = 1'b0;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int   gr[$];
    bit   drop[N];
    bit   rearm[N];
    bit   seen;
    bit   gap;
    bit   got;
    int   n;

    rq.req_valid_i = '0;
    rq.req_cmd_i   = '0;
    rq.req_addr_i  = '0;
    rq.req_data_i  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd", 32'(dbg_cmd), 32'h0);
    chk("rst_rsp", 32'(rq.rsp_valid_o), 32'h0);
    chk("rst_halt", 32'(halted), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Simultaneous requests: req0 first, then req1, with a gap.
    @(posedge clk); #1;
    set_req(0, 8'h05, 32'h0, 32'h0);
    set_req(1, 8'h05, 32'h0, 32'h0);
    rq.req_valid_i = 2'b11;
    @(negedge clk);
    chk("t2_ready0", 32'(rq.req_ready_o), 32'h1);
    push(0, PC, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i[0] = 1'b0;
    seen = 1'b0;
    gap  = 1'b0;
    got  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dbg_cmd != 8'h00) seen = 1'b1;
      else if (seen) gap = 1'b1;
      if (rq.req_ready_o[1]) begin
        got = 1'b1;
        break;
      end
    end
    chk("t2_ready1", 32'(got), 32'h1);
    chk("t2_gap", 32'(gap), 32'h1);
    push(1, PC, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i[1] = 1'b0;
    wait_idle("t2_idle");

    // Fairness: both requesters re-request after each response.
    set_req(0, 8'h04, 32'h10, 32'h0);
    set_req(1, 8'h04, 32'h20, 32'h0);
    drop  = '{default: 1'b0};
    rearm = '{default: 1'b0};
    @(posedge clk); #1;
    rq.req_valid_i = 2'b11;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int id = 0; id < N; id++) begin
        if (rq.req_ready_o[id]) begin
          gr.push_back(id);
          push(id, 32'h10 * (id + 1) + 1, 1'b0);
          drop[id] = 1'b1;
        end
        if (rq.rsp_valid_o[id]) rearm[id] = 1'b1;
      end
      if (gr.size() >= 4 && !busy && rq.req_valid_i == '0)
        break;
      @(posedge clk); #1;
      for (int id = 0; id < N; id++) begin
        if (drop[id]) rq.req_valid_i[id] = 1'b0;
        if (rearm[id]) rq.req_valid_i[id] = 1'b1;
        drop[id]  = 1'b0;
        rearm[id] = 1'b0;
      end
      if (gr.size() >= 4) rq.req_valid_i = '0;
    end
    chk("t3_ngrant", 32'(gr.size()), 32'h4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_grant%0d", k),
          (k < gr.size()) ? 32'(gr[k]) : 32'hff, 32'(k % 2));
    wait_idle("t3_idle");

    // Halt command latency.
    @(posedge clk); #1;
    set_req(0, 8'h01, 32'h100, 32'h0);
    rq.req_valid_i = 2'b01;
    @(negedge clk);
    chk("t1_ready", 32'(rq.req_ready_o), 32'h1);
    push(0, 32'h101, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i = '0;
    @(negedge clk);
    chk("t1_cmd", 32'(dbg_cmd), 32'h1);
    chk("t1_addr", dbg_addr, 32'h100);
    @(negedge clk);
    chk("t1_rsp_early", 32'(rq.rsp_valid_o), 32'h0);
    @(negedge clk);
    chk("t1_rsp", 32'(rq.rsp_valid_o), 32'h1);
    chk("t1_halt", 32'(halted), 32'h1);
    wait_idle("t1_idle");

    // No-command request never touches the bus.
    @(posedge clk); #1;
    set_req(0, 8'h00, 32'h123, 32'h456);
    rq.req_valid_i = 2'b01;
    @(negedge clk);
    chk("t4_ready", 32'(rq.req_ready_o), 32'h1);
    chk("t4_busy0", 32'(busy), 32'h0);
    push(0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i = '0;
    @(negedge clk);
    chk("t4_rsp", 32'(rq.rsp_valid_o), 32'h1);
    chk("t4_busy1", 32'(busy), 32'h0);
    chk("t4_cmd", 32'(dbg_cmd), 32'h0);

    // Unsupported command times out.
    @(posedge clk); #1;
    set_req(0, 8'h07, 32'h200, 32'hdead);
    rq.req_valid_i = 2'b01;
    @(negedge clk);
    chk("t5_ready", 32'(rq.req_ready_o), 32'h1);
    push(0, 32'h0, 1'b1);
    @(posedge clk); #1;
    rq.req_valid_i = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_cmd == 8'h07) n++;
      else break;
    end
    chk("t5_len", 32'(n), 32'(TO));
    chk("t5_rsp", 32'(rq.rsp_valid_o), 32'h1);
    chk("t5_halt", 32'(halted), 32'h1);
    wait_idle("t5_idle");
    do_req("t5_resume", 0, 8'h02, 32'h40, 32'h41);
    chk("t5_unhalt", 32'(halted), 32'h0);

    // Reset in the middle of ISSUE.
    @(posedge clk); #1;
    set_req(0, 8'h03, 32'h300, 32'h55);
    rq.req_valid_i = 2'b01;
    @(negedge clk);
    chk("t6_ready", 32'(rq.req_ready_o), 32'h1);
    @(posedge clk); #1;
    rq.req_valid_i = '0;
    @(negedge clk);
    chk("t6_issue", 32'(dbg_cmd), 32'h3);
    rstn = 1'b0;
    #1;
    chk("t6_cmd", 32'(dbg_cmd), 32'h0);
    chk("t6_addr", dbg_addr, 32'h0);
    chk("t6_data", dbg_wdata, 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_rsp", 32'(rq.rsp_valid_o), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    set_req(0, 8'h04, 32'h500, 32'h0);
    set_req(1, 8'h04, 32'h600, 32'h0);
    rq.req_valid_i = 2'b11;
    @(negedge clk);
    chk("t6_prio", 32'(rq.req_ready_o), 32'h1);
    push(0, 32'h501, 1'b0);
    @(posedge clk); #1;
    rq.req_valid_i = '0;
    wait_idle("t6_idle");
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
